// File: rtl/mem_controller.sv
// Word-organised synchronous memory behind a MemEnable/MemRdy request/acknowledge
// handshake. Supports 32-bit word and 8-bit byte accesses, programmable wait states,
// and a separate error flag for command, alignment and range errors.
module mem_controller #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [23:0] MemAddr,
  input  logic [31:0] toMemData,
  output logic [31:0] fromMemData,
  input  logic        MemLength,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic        MemEnable,
  output logic        MemRdy,
  output logic        MemErr
);

  localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        len_q, len_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        rdy_q, rdy_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [21:0]     word_idx;
  logic [IdxW-1:0] mem_idx;
  logic [1:0]      lane;
  logic            in_range;
  logic            acc_err;
  logic [31:0]     cur_word;
  logic [7:0]      cur_byte;
  logic [31:0]     merged_word;
  logic            commit;
  logic            mem_we;

  // Decode the captured request: index, lane, error classification and lane data.
  always_comb begin
    word_idx    = addr_q[23:2];
    lane        = addr_q[1:0];
    mem_idx     = word_idx[IdxW-1:0];
    in_range    = 32'(word_idx) < DEPTH_WORDS;
    acc_err     = (rd_q == wr_q) || (len_q && (lane != 2'd0)) || !in_range;
    // Guard the array read so out-of-range indices never touch storage.
    cur_word    = in_range ? mem_q[mem_idx] : 32'h0;
    cur_byte    = cur_word[{lane, 3'b000} +: 8];
    merged_word = cur_word;
    merged_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
    commit      = (state_q == StWait) && MemEnable && (cnt_q == 4'd0);
    // Reset on the commit edge suppresses the write.
    mem_we      = commit && !Reset && !acc_err && wr_q;
  end

  // Storage array; intentionally not cleared by reset.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= len_q ? wdata_q : merged_word;
    end
  end

  // Next-state and output logic for the request handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdy_d   = rdy_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (MemEnable) begin
          addr_d  = MemAddr;
          wdata_d = toMemData;
          len_d   = MemLength;
          rd_d    = MemRd;
          wr_d    = MemWr;
          cnt_d   = CntInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (!MemEnable) begin
          // Requester withdrew: abandon without side effects.
          cnt_d   = 4'd0;
          state_d = StIdle;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdy_d   = 1'b1;
          err_d   = acc_err;
          state_d = StDone;
          if (acc_err) begin
            rdata_d = 32'h0;
          end else if (rd_q) begin
            rdata_d = len_q ? cur_word : {24'h0, cur_byte};
          end
        end
      end
      StDone: begin
        if (!MemEnable) begin
          rdy_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 24'h0;
      wdata_q <= 32'h0;
      len_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign fromMemData = rdata_q;
  assign MemRdy      = rdy_q;
  assign MemErr      = err_q;

endmodule

// File: tb/tb_mem_controller.sv
// Directed self-checking bench for mem_controller (DEPTH_WORDS=1024, LATENCY=2).
module tb_mem_controller;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [23:0] MemAddr = 24'h0;
  logic [31:0] toMemData = 32'h0;
  logic [31:0] fromMemData;
  logic        MemLength = 1'b1;
  logic        MemRd = 1'b0;
  logic        MemWr = 1'b0;
  logic        MemEnable = 1'b0;
  logic        MemRdy;
  logic        MemErr;

  int          errors = 0;
  int          checks = 0;
  int          lat_g;
  logic [31:0] rdata_g;
  logic        err_g;
  logic [31:0] held;

  mem_controller #(
    .DEPTH_WORDS(1024),
    .LATENCY    (2)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .MemAddr    (MemAddr),
    .toMemData  (toMemData),
    .fromMemData(fromMemData),
    .MemLength  (MemLength),
    .MemRd      (MemRd),
    .MemWr      (MemWr),
    .MemEnable  (MemEnable),
    .MemRdy     (MemRdy),
    .MemErr     (MemErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Raise a request and wait (bounded) for MemRdy; lat_g counts edges after capture.
  task automatic issue(input logic [23:0] a, input logic [31:0] d, input logic len,
                       input logic rd, input logic wr);
    logic seen;
    @(negedge Clk);
    MemAddr = a; toMemData = d; MemLength = len; MemRd = rd; MemWr = wr; MemEnable = 1'b1;
    @(posedge Clk);
    lat_g = 0;
    seen  = 1'b0;
    while (!seen && lat_g < 20) begin
      @(posedge Clk);
      #1;
      lat_g++;
      seen = MemRdy;
    end
    rdata_g = fromMemData;
    err_g   = MemErr;
  endtask

  // Drop MemEnable and confirm MemRdy/MemErr clear one edge later.
  task automatic release_req(input string tag);
    @(negedge Clk);
    MemEnable = 1'b0;
    @(posedge Clk);
    #1;
    check({tag, " rdy clear"}, {31'h0, MemRdy}, 32'h0);
    check({tag, " err clear"}, {31'h0, MemErr}, 32'h0);
  endtask

  task automatic access(input logic [23:0] a, input logic [31:0] d, input logic len,
                        input logic rd, input logic wr);
    issue(a, d, len, rd, wr);
    @(negedge Clk);
    MemEnable = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Reset for two cycles.
    repeat (2) @(posedge Clk);
    #1;
    check("reset rdy", {31'h0, MemRdy}, 32'h0);
    check("reset err", {31'h0, MemErr}, 32'h0);
    check("reset data", fromMemData, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    // Word write then read, latency 2.
    issue(24'h000010, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
    check("wr latency", 32'(lat_g), 32'd2);
    check("wr err", {31'h0, err_g}, 32'h0);
    check("wr keeps data", rdata_g, 32'h0);
    release_req("wr");
    issue(24'h000010, 32'h0, 1'b1, 1'b1, 1'b0);
    check("rd latency", 32'(lat_g), 32'd2);
    check("rd data", rdata_g, 32'hDEADBEEF);
    check("rd err", {31'h0, err_g}, 32'h0);
    release_req("rd");

    // Byte lanes.
    access(24'h000020, 32'h11223344, 1'b1, 1'b0, 1'b1);
    check("wr20 keeps prior data", rdata_g, 32'hDEADBEEF);
    access(24'h000022, 32'hFFFFFFAA, 1'b0, 1'b0, 1'b1);
    check("byte wr err", {31'h0, err_g}, 32'h0);
    access(24'h000020, 32'h0, 1'b1, 1'b1, 1'b0);
    check("word after byte wr", rdata_g, 32'h11AA3344);
    access(24'h000023, 32'h0, 1'b0, 1'b1, 1'b0);
    check("byte rd lane3", rdata_g, 32'h00000011);
    access(24'h000020, 32'h0, 1'b0, 1'b1, 1'b0);
    check("byte rd lane0", rdata_g, 32'h00000044);

    // Misaligned word read.
    access(24'h000006, 32'h0, 1'b1, 1'b1, 1'b0);
    check("misalign err", {31'h0, err_g}, 32'h1);
    check("misalign data", rdata_g, 32'h0);

    // Out-of-range write must not alias onto any word.
    access(24'h000000, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1);
    access(24'h000FFC, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b1);
    access(24'h001000, 32'hBADBAD00, 1'b1, 1'b0, 1'b1);
    check("range err", {31'h0, err_g}, 32'h1);
    check("range data", rdata_g, 32'h0);
    access(24'h000000, 32'h0, 1'b1, 1'b1, 1'b0);
    check("range nbr0", rdata_g, 32'hA5A5A5A5);
    access(24'h000FFC, 32'h0, 1'b1, 1'b1, 1'b0);
    check("range nbr1023", rdata_g, 32'h5A5A5A5A);

    // Command errors.
    access(24'h000010, 32'h0, 1'b1, 1'b1, 1'b1);
    check("rdwr both err", {31'h0, err_g}, 32'h1);
    check("rdwr both data", rdata_g, 32'h0);
    access(24'h000010, 32'h0, 1'b1, 1'b0, 1'b0);
    check("rdwr none err", {31'h0, err_g}, 32'h1);
    access(24'h000010, 32'h0, 1'b1, 1'b1, 1'b0);
    check("err cmd no write", rdata_g, 32'hDEADBEEF);

    // Abort after one WAIT edge.
    @(negedge Clk);
    MemAddr = 24'h000010; toMemData = 32'h12345678; MemLength = 1'b1;
    MemRd = 1'b0; MemWr = 1'b1; MemEnable = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    MemEnable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      #1;
      check("abort no rdy", {31'h0, MemRdy}, 32'h0);
    end
    access(24'h000010, 32'h0, 1'b1, 1'b1, 1'b0);
    check("abort no write", rdata_g, 32'hDEADBEEF);

    // Reset on the commit edge.
    @(negedge Clk);
    MemAddr = 24'h000010; toMemData = 32'hCAFEF00D; MemLength = 1'b1;
    MemRd = 1'b0; MemWr = 1'b1; MemEnable = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("rst commit rdy", {31'h0, MemRdy}, 32'h0);
    check("rst commit data", fromMemData, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    MemEnable = 1'b0;
    access(24'h000010, 32'h0, 1'b1, 1'b1, 1'b0);
    check("rst idle latency", 32'(lat_g), 32'd2);
    check("rst no write", rdata_g, 32'hDEADBEEF);

    // Hold MemEnable past MemRdy while the address wanders.
    issue(24'h000020, 32'h0, 1'b1, 1'b1, 1'b0);
    check("hold first data", rdata_g, 32'h11AA3344);
    held = rdata_g;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      MemAddr = MemAddr + 24'h4;
      @(posedge Clk);
      #1;
      check("hold rdy", {31'h0, MemRdy}, 32'h1);
      check("hold data", fromMemData, held);
    end
    release_req("hold");
    check("hold data after drop", fromMemData, 32'h11AA3344);
    issue(24'h000000, 32'h0, 1'b1, 1'b1, 1'b0);
    check("next req latency", 32'(lat_g), 32'd2);
    check("next req data", rdata_g, 32'hA5A5A5A5);
    release_req("next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_controller.md
# mem_controller

Word-organised synchronous memory with programmable wait states. It sits directly downstream of the processor's memory bus and serves its MemEnable/MemRd/MemWr/MemRdy request/acknowledge handshake. It supports 32-bit word and 8-bit byte accesses. Alignment, range and command errors are reported on a separate flag.

## Interface

Parameters:

- DEPTH_WORDS, 1024: number of 32-bit words stored. Valid word indices are 0..DEPTH_WORDS-1.
- LATENCY, 2: wait states, legal range 1..15. This is the number of clock edges from request capture to MemRdy rising.

Ports:

- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- MemAddr  input  24  byte address. Word index is MemAddr[23:2]; byte lane is MemAddr[1:0].
- toMemData  input  32  write data from the processor. Byte writes take bits [7:0].
- fromMemData  output  32  read data to the processor.
- MemLength  input  1  operand length: 1 = word, 0 = byte.
- MemRd  input  1  read command.
- MemWr  input  1  write command.
- MemEnable  input  1  request strobe; held high until MemRdy is seen.
- MemRdy  output  1  completion acknowledge.
- MemErr  output  1  error flag; valid while MemRdy=1.

## Operation

- State machine with three states: IDLE, WAIT, DONE.
- **IDLE**
  - On an edge with MemEnable=1: latch MemAddr, toMemData, MemLength, MemRd and MemWr.
  - Load the wait counter with LATENCY-1 and go to WAIT.
  - Inputs that change after capture are ignored.
- **WAIT**
  - While counter≠0: decrement each edge.
  - On the edge where counter=0: perform the access, set MemRdy=1 and go to DONE.
  - If MemEnable=0 on any WAIT edge: abort. Return to IDLE with no write and no MemRdy.
- **DONE**
  - MemRdy=1; fromMemData and MemErr are held stable.
  - On the first edge with MemEnable=0: clear MemRdy and MemErr and return to IDLE. fromMemData keeps its last value.
- **Error conditions.** Any of the following sets MemErr=1; the access still completes with MemRdy; no memory write occurs; fromMemData=0.
  - MemRd=MemWr (both high or both low).
  - Word access with MemAddr[1:0]≠0.
  - Word index ≥ DEPTH_WORDS.
- **Word read:** fromMemData = mem[idx].
- **Byte read:** fromMemData = {24'b0, mem[idx][8k+7:8k]}, where k = MemAddr[1:0]. Little-endian lanes; zero-extended.
- **Word write:** mem[idx] = toMemData.
- **Byte write:** only lane k is updated, with toMemData[7:0]; the other three lanes are unchanged.
- **Writes:** a write updates memory on the same edge that raises MemRdy. fromMemData keeps its previous value on writes.
- **Memory contents:** not cleared by Reset. Initial contents are undefined.

## Timing

- **Reset (synchronous):** at the next edge, MemRdy=0, MemErr=0, fromMemData=32'h0, state=IDLE and counter=0.
- **Reset mid-operation:** Reset in WAIT aborts the access with no write. Reset on the same edge as the commit takes priority, so no write occurs.
- **Latency:** capture at edge t0; MemRdy and data are valid after edge t0+LATENCY.
  - LATENCY=1: MemRdy is high after edge t0+1.
- **Back-to-back requests:** MemEnable must be low for at least one edge (DONE→IDLE) before the next capture. Minimum request period is LATENCY+2 cycles.
- **Combinational paths:** none; all outputs are registered.

## Test plan

- **Reset and word write/read, LATENCY=2:** Reset for 2 cycles → MemRdy=0, fromMemData=0. Write word 32'hDEADBEEF at 24'h000010 → MemRdy high exactly 2 edges after capture, MemErr=0. Read back the same address → fromMemData=32'hDEADBEEF.
- **Byte lanes:** word 32'h11223344 at 24'h20. Byte write 8'hAA at 24'h22 → a word read returns 32'h11AA3344. Byte read at 24'h23 → 32'h00000011.
- **Errors, one each:**
  - Word read at 24'h000006 (misaligned) → MemErr=1, fromMemData=0.
  - Word write at byte address 4*DEPTH_WORDS → MemErr=1 and memory is unchanged; check by reading neighbours.
  - MemRd=MemWr=1 → MemErr=1.
- **Abort:** MemEnable dropped after 1 WAIT edge of a write of 32'h12345678 → MemRdy never rises; a later read returns the old value.
- **Reset mid-write:** Reset asserted on the commit edge → no write, MemRdy=0, state IDLE.
- **Handshake hold:** MemEnable held 5 cycles past MemRdy with a changing MemAddr → MemRdy and fromMemData stay constant. MemRdy clears one edge after MemEnable falls. A new request captures on the following edge.
